// File: rtl/bitty_fetch_unit.sv
// -----------------------------------------------------------------------------
// bitty_fetch_unit
//
// Instruction sequencer for the bitty control unit. It reads one 16-bit word at
// a time from a synchronous-read instruction memory and presents it on
// `instruction` with `run` high. It then waits for the control unit's one-cycle
// `done` pulse and moves on to the next address. This block owns the program
// counter, the run/done handshake, end-of-program detection and a stall
// watchdog.
//
// Per-instruction loop (start-to-start), with a control unit that answers three
// cycles after `run` rises:
//   FETCH (1) -> WAIT_MEM (1) -> ISSUE (1) -> WAIT_DONE (4) = 7 cycles.
// `run` therefore stays low for at least 3 cycles between two instructions.
//
// Parameters
//   ADDR_W      PC / instruction memory address width.
//   TIMEOUT     Maximum number of cycles `run` may stay high without `done`
//               before the watchdog trips. Must be >= 4 so that a healthy
//               control unit cannot trip it.
//
// Ports
//   clk          in   single clock; all state changes on the rising edge
//   reset        in   asynchronous, active-low; clears all state while low
//   start        in   one-cycle pulse; starts a program (IDLE or ERROR only)
//   start_addr   in   first PC, sampled on `start`
//   end_addr     in   last PC to execute, sampled on `start`
//   halt         in   level; sampled only on the `done` edge, ends the program
//   mem_addr     out  instruction memory address
//   mem_rd_en    out  read strobe; `mem_rdata` is valid on the following cycle
//   mem_rdata    in   instruction word from memory
//   instruction  out  word for the control unit; stable while `run` is high
//   run          out  execute request to the control unit
//   done         in   control unit completion pulse; ignored outside WAIT_DONE
//   pc           out  address of the current / next instruction
//   instr_count  out  instructions retired since `start`; wraps at 2^16
//   busy         out  high in every state except IDLE and ERROR
//   finished     out  one-cycle pulse when a program ends normally
//   error        out  sticky watchdog flag; cleared by the next `start`
// -----------------------------------------------------------------------------
module bitty_fetch_unit #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic              halt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       instruction,
    output logic              run,
    input  logic              done,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       instr_count,
    output logic              busy,
    output logic              finished,
    output logic              error
);

    // Watchdog counter wide enough to hold TIMEOUT itself.
    localparam int unsigned     WD_W    = $clog2(TIMEOUT + 1);
    // The count compared here is the value before the current edge, so the
    // trip happens on the TIMEOUT-th WAIT_DONE edge after `run` rose.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWaitMem,
        StIssue,
        StWaitDone,
        StError
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] end_addr_q;
    logic [WD_W-1:0]   wd_q;

    logic [ADDR_W-1:0] pc_inc;
    logic              last_instr;

    // Next sequential address; wraps modulo 2^ADDR_W so that a program with
    // start_addr > end_addr runs through the top of memory and back to 0.
    assign pc_inc = pc + ADDR_W'(1);

    // Retiring the instruction at end_addr, or retiring with halt high, ends
    // the program. halt matters only on the edge where done is sampled.
    assign last_instr = (pc == end_addr_q) || halt;

    // -------------------------------------------------------------------------
    // Sequencer. All outputs are registered. mem_rd_en and finished are
    // single-cycle strobes: they default low on every edge and are set only on
    // the transition that needs them.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            end_addr_q  <= '0;
            wd_q        <= '0;
            pc          <= '0;
            mem_addr    <= '0;
            mem_rd_en   <= 1'b0;
            instruction <= '0;
            run         <= 1'b0;
            instr_count <= '0;
            busy        <= 1'b0;
            finished    <= 1'b0;
            error       <= 1'b0;
        end else begin
            mem_rd_en <= 1'b0;
            finished  <= 1'b0;

            unique case (state_q)
                // IDLE and ERROR behave the same way on start. In ERROR, the
                // other outputs keep the values they had when the watchdog
                // tripped, so the failing PC remains visible.
                StIdle, StError: begin
                    if (start) begin
                        pc          <= start_addr;
                        mem_addr    <= start_addr;
                        mem_rd_en   <= 1'b1;
                        end_addr_q  <= end_addr;
                        instr_count <= '0;
                        error       <= 1'b0;
                        busy        <= 1'b1;
                        state_q     <= StFetch;
                    end
                end

                // The read strobe is already on the bus for this cycle; the
                // word appears on mem_rdata during the next cycle.
                StFetch: begin
                    state_q <= StWaitMem;
                end

                StWaitMem: begin
                    instruction <= mem_rdata;
                    state_q     <= StIssue;
                end

                StIssue: begin
                    run     <= 1'b1;
                    wd_q    <= '0;
                    state_q <= StWaitDone;
                end

                // done takes priority over the watchdog on the same edge.
                StWaitDone: begin
                    if (done) begin
                        run         <= 1'b0;
                        instr_count <= instr_count + 16'd1;
                        if (last_instr) begin
                            finished <= 1'b1;
                            busy     <= 1'b0;
                            state_q  <= StIdle;
                        end else begin
                            pc        <= pc_inc;
                            mem_addr  <= pc_inc;
                            mem_rd_en <= 1'b1;
                            state_q   <= StFetch;
                        end
                    end else if (wd_q == WD_LAST) begin
                        run     <= 1'b0;
                        error   <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StError;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end

                default: begin
                    run     <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitty_fetch_unit.sv
// -----------------------------------------------------------------------------
// Testbench for bitty_fetch_unit.
//
// A reference model builds the expected list of fetched addresses, issued words
// and end-of-program state for each program. A separate monitor process checks
// them against every read strobe, every rising edge of run and every finished
// pulse. A small control-unit model answers run with done three cycles later.
// -----------------------------------------------------------------------------
module tb_bitty_fetch_unit;

    localparam int unsigned AW = 8;
    localparam int unsigned TO = 16;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] end_addr;
    logic          halt;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic [15:0]   mem_rdata;
    logic [15:0]   instruction;
    logic          run;
    logic          done;
    logic [AW-1:0] pc;
    logic [15:0]   instr_count;
    logic          busy;
    logic          finished;
    logic          error;

    logic [15:0]   mem [256];

    int n_vec = 0;
    int n_err = 0;

    // Scoreboard queues, filled by the stimulus and drained by the monitor.
    logic [AW-1:0] exp_fetch[$];
    logic [15:0]   exp_issue[$];
    logic [AW-1:0] exp_fin_pc[$];
    logic [15:0]   exp_fin_cnt[$];

    // Control-unit model state.
    bit cu_en     = 1'b1;
    bit spur      = 1'b0;
    bit real_pend = 1'b0;
    bit glitch    = 1'b0;
    int cu_cnt    = 0;
    int done_cnt  = 0;
    int halt_at_v = 0;

    bitty_fetch_unit #(
        .ADDR_W  (AW),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .start_addr  (start_addr),
        .end_addr    (end_addr),
        .halt        (halt),
        .mem_addr    (mem_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_rdata   (mem_rdata),
        .instruction (instruction),
        .run         (run),
        .done        (done),
        .pc          (pc),
        .instr_count (instr_count),
        .busy        (busy),
        .finished    (finished),
        .error       (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: actual still running required finished");
        $fatal(1, "simulation time limit");
    end

    // Synchronous-read instruction memory.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Control-unit model. It drives done high during the fourth cycle run is
    // seen high, so done is sampled on the fourth edge after run rises. The
    // model also drives halt: a level derived from the retired count, plus an
    // optional glitch that is released before done.
    initial begin
        done = 1'b0;
        halt = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                done = 1'b0; cu_cnt = 0; real_pend = 1'b0;
            end else if (done) begin
                done = 1'b0; cu_cnt = 0;
                if (real_pend) done_cnt++;
                real_pend = 1'b0;
            end else if (spur) begin
                done = 1'b1; spur = 1'b0;
            end else if (run && cu_en) begin
                cu_cnt++;
                if (cu_cnt == 4) begin
                    done = 1'b1; real_pend = 1'b1;
                end
            end else begin
                cu_cnt = 0;
            end
            halt = (halt_at_v != 0 && done_cnt >= halt_at_v - 1) ||
                   (glitch && run && cu_cnt == 2);
        end
    end

    // Monitor: compares every DUT event against the scoreboard.
    initial begin
        bit          prev_run;
        int          low;
        logic [15:0] held;
        prev_run = 1'b0;
        low      = 100;
        held     = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                prev_run = 1'b0;
                low      = 100;
            end else begin
                if (mem_rd_en) begin
                    if (exp_fetch.size() == 0) chk("unexpected_fetch", {24'd0, mem_addr}, 32'hffff_ffff);
                    else chk("fetch_addr", {24'd0, mem_addr}, {24'd0, exp_fetch.pop_front()});
                end
                if (run && !prev_run) begin
                    chk("run_gap_ge3", {31'd0, (low >= 3)}, 32'd1);
                    if (exp_issue.size() == 0) chk("unexpected_run", {16'd0, instruction}, 32'hffff_ffff);
                    else chk("issue_word", {16'd0, instruction}, {16'd0, exp_issue.pop_front()});
                    held = instruction;
                end else if (run) begin
                    chk("instr_stable", {16'd0, instruction}, {16'd0, held});
                end
                if (finished) begin
                    if (exp_fin_pc.size() == 0) begin
                        chk("unexpected_finished", 32'd1, 32'd0);
                    end else begin
                        chk("fin_pc", {24'd0, pc}, {24'd0, exp_fin_pc.pop_front()});
                        chk("fin_count", {16'd0, instr_count}, {16'd0, exp_fin_cnt.pop_front()});
                        chk("fin_busy", {31'd0, busy}, 32'd0);
                    end
                end
                low      = run ? 0 : low + 1;
                prev_run = run;
            end
        end
    end

    task automatic pulse_start(input logic [AW-1:0] sa, input logic [AW-1:0] ea);
        @(negedge clk);
        start_addr = sa;
        end_addr   = ea;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic clear_sb();
        exp_fetch.delete();
        exp_issue.delete();
        exp_fin_pc.delete();
        exp_fin_cnt.delete();
    endtask

    // Reference model: walk the PC from sa, wrapping at 2^AW, until end_addr or
    // the halt point. Then run the program and check the totals.
    task automatic run_prog(input logic [AW-1:0] sa, input logic [AW-1:0] ea,
                            input int halt_at, input bit gl);
        logic [AW-1:0] p;
        int            n;
        int            k;
        p = sa;
        n = 0;
        for (int i = 0; i < 256; i++) begin
            exp_fetch.push_back(p);
            exp_issue.push_back(mem[p]);
            n++;
            if (p == ea || (halt_at != 0 && n >= halt_at)) break;
            p = p + 8'd1;
        end
        exp_fin_pc.push_back(p);
        exp_fin_cnt.push_back(16'(n));
        done_cnt  = 0;
        halt_at_v = halt_at;
        glitch    = gl;
        pulse_start(sa, ea);
        chk("start_error_clr", {31'd0, error}, 32'd0);
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_pc", {24'd0, pc}, {24'd0, sa});
        chk("start_count", {16'd0, instr_count}, 32'd0);
        k = 0;
        while (busy && k < n * 7 + 30) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("busy_drop", {31'd0, busy}, 32'd0);
        chk("prog_cycles", k, 7 * n);
        chk("end_pc", {24'd0, pc}, {24'd0, p});
        chk("end_count", {16'd0, instr_count}, n);
        @(posedge clk);
        #1;
        chk("sb_fetch_empty", exp_fetch.size(), 0);
        chk("sb_issue_empty", exp_issue.size(), 0);
        chk("sb_fin_empty", exp_fin_pc.size(), 0);
        clear_sb();
        halt_at_v = 0;
        glitch    = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"}, {24'd0, pc}, 32'd0);
        chk({tag, "_mem_addr"}, {24'd0, mem_addr}, 32'd0);
        chk({tag, "_mem_rd_en"}, {31'd0, mem_rd_en}, 32'd0);
        chk({tag, "_instruction"}, {16'd0, instruction}, 32'd0);
        chk({tag, "_run"}, {31'd0, run}, 32'd0);
        chk({tag, "_count"}, {16'd0, instr_count}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_finished"}, {31'd0, finished}, 32'd0);
        chk({tag, "_error"}, {31'd0, error}, 32'd0);
    endtask

    initial begin
        int            w;
        int            n;
        logic [AW-1:0] sa;
        int            len;
        int            hat;

        reset      = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        end_addr   = '0;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);

        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Three-word program at addresses 4..6.
        run_prog(8'd4, 8'd6, 0, 1'b0);

        // Single instruction: one fetch, one run window, finished after 7 cycles.
        run_prog(8'd9, 8'd9, 0, 1'b0);

        // halt raised after the first retire of a 5-word program.
        run_prog(8'd20, 8'd24, 2, 1'b0);

        // A halt glitch released before done has no effect.
        run_prog(8'd60, 8'd62, 0, 1'b1);

        // Watchdog: control unit never answers.
        cu_en = 1'b0;
        exp_fetch.push_back(8'd40);
        exp_issue.push_back(mem[40]);
        pulse_start(8'd40, 8'd40);
        w = 0;
        while (!run && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("to_run_rise", {31'd0, run}, 32'd1);
        n = 0;
        while (run && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("to_run_width", n, TO);
        chk("to_error", {31'd0, error}, 32'd1);
        chk("to_busy", {31'd0, busy}, 32'd0);
        chk("to_pc", {24'd0, pc}, 32'd40);
        chk("to_count", {16'd0, instr_count}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("to_error_sticky", {31'd0, error}, 32'd1);
        chk("to_run_low", {31'd0, run}, 32'd0);
        chk("to_pc_frozen", {24'd0, pc}, 32'd40);
        chk("to_sb_empty", exp_fetch.size() + exp_issue.size(), 0);
        cu_en = 1'b1;
        run_prog(8'd50, 8'd52, 0, 1'b0);

        // PC wraps through the top of the address space.
        run_prog(8'd254, 8'd1, 0, 1'b0);

        // Asynchronous reset in the middle of WAIT_DONE.
        exp_fetch.push_back(8'd30);
        exp_issue.push_back(mem[30]);
        pulse_start(8'd30, 8'd35);
        w = 0;
        while (!run && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("mid_run_rise", {31'd0, run}, 32'd1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk_reset_vals("async");
        clear_sb();
        @(negedge clk);
        reset = 1'b1;
        spur  = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("spur_run", {31'd0, run}, 32'd0);
        chk("spur_busy", {31'd0, busy}, 32'd0);
        chk("spur_count", {16'd0, instr_count}, 32'd0);

        // Randomized programs, with optional halt, halt glitch and idle done.
        for (int t = 0; t < 12; t++) begin
            sa  = 8'($urandom);
            len = $urandom_range(1, 6);
            hat = ($urandom_range(0, 2) == 0) ? $urandom_range(1, len) : 0;
            if ($urandom_range(0, 1) == 1) begin
                spur = 1'b1;
                repeat (2) @(posedge clk);
            end
            run_prog(sa, sa + 8'(len - 1), hat, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bitty_fetch_unit.md
# bitty_fetch_unit

Instruction sequencer that drives the bitty control unit from the issuing side. Reads 16-bit instructions from a synchronous-read instruction memory, presents each one on `instruction` with `run` held high, waits for the control unit's `done` pulse, then advances the program counter. Sits between instruction memory and the control unit; owns PC, run/done handshake, end-of-program detection and a stall watchdog.

## Interface
- `ADDR_W`, 8: PC / memory address width.
- `TIMEOUT`, 16: max cycles `run` may stay high without `done` before error; must be ≥ 4.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low; all state cleared while low.
- `start` in 1: one-cycle pulse; begins execution at `start_addr` (IDLE or ERROR only).
- `start_addr` in ADDR_W: first PC, sampled on `start`.
- `end_addr` in ADDR_W: last PC to execute, sampled on `start`.
- `halt` in 1: level; stop after the in-flight instruction completes.
- `mem_addr` out ADDR_W: instruction memory address.
- `mem_rd_en` out 1: read strobe; data valid on `mem_rdata` the next cycle.
- `mem_rdata` in 16: instruction word from memory.
- `instruction` out 16: word to control unit; stable whenever `run`=1.
- `run` out 1: execute request to control unit.
- `done` in 1: control unit completion pulse (one cycle).
- `pc` out ADDR_W: address of current/next instruction.
- `instr_count` out 16: instructions retired since `start`, wraps at 2^16.
- `busy` out 1: high in any state other than IDLE/ERROR.
- `finished` out 1: one-cycle pulse when a program ends normally.
- `error` out 1: sticky watchdog flag.

## Operation
- States: IDLE, FETCH, WAIT_MEM, ISSUE, WAIT_DONE, ERROR.
- IDLE: `start` → pc←`start_addr`, latch `end_addr`, instr_count←0, error←0, → FETCH. `start` ignored in other states except ERROR.
- FETCH: `mem_addr`=pc, `mem_rd_en`=1 for one cycle → WAIT_MEM.
- WAIT_MEM: `instruction`←`mem_rdata` → ISSUE.
- ISSUE: `run`←1 → WAIT_DONE; watchdog cleared.
- WAIT_DONE: `run` held 1, `instruction` frozen. On `done`=1: `run`←0, instr_count+1; then
  - pc == latched end_addr, or `halt`=1: `finished` pulse, → IDLE, pc unchanged.
  - else pc←pc+1 (wraps mod 2^ADDR_W), → FETCH.
- Watchdog: counts cycles in WAIT_DONE; reaching TIMEOUT without `done` → `run`←0, `error`←1, → ERROR. `done` on the same cycle the count hits TIMEOUT wins (normal retire).
- ERROR: outputs frozen except `run`=0, `busy`=0; `start` restarts exactly as from IDLE.
- `done` outside WAIT_DONE is ignored.
- `start_addr` > `end_addr`: pc wraps through 2^ADDR_W−1 to 0 and on to end_addr.

## Timing
- Reset values: state IDLE, `pc`=0, `mem_addr`=0, `mem_rd_en`=0, `instruction`=0, `run`=0, `instr_count`=0, `busy`=0, `finished`=0, `error`=0.
- `run` drops on the same edge at which `done`=1 is sampled; the control unit therefore finishes its clear-enables step while `run` is still high.
- Per-instruction loop: FETCH 1 + WAIT_MEM 1 + ISSUE 1 + WAIT_DONE (control unit latency, 3 cycles to `done`, +1 sample) = 7 cycles per instruction start-to-start.
- `run` never high for two separate instructions without at least 3 low cycles between.
- `halt` is sampled only on the `done` edge; asserting and releasing it mid-instruction has no effect.
- Reset low mid-instruction: `run` falls immediately (async); no `finished`, no count update.

## Test plan
- Program of 3 words at addr 4..6, `start` with start_addr=4, end_addr=6 → three `run` windows with matching `instruction`, instr_count=3, `finished` one cycle, pc=6, busy=0.
- Single instruction, start_addr=end_addr=9 → exactly one `mem_rd_en`, one `run` window, `finished` pulse 7 cycles after `start`.
- `halt` held high from instruction 2 of a 5-word program → stops after 2nd `done`, instr_count=2, `finished` pulse, pc unchanged.
- `done` tied low, TIMEOUT=16 → `run` drops 16 cycles after rising, `error`=1, busy=0; new `start` clears error and runs normally.
- ADDR_W=8, start_addr=254, end_addr=1 → pcs 254,255,0,1 fetched in order, instr_count=4.
- Reset pulled low during WAIT_DONE → all outputs at reset values same cycle; spurious `done` afterwards ignored.
